// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ_C = 8;
    localparam int unsigned IDX_W_C = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/idx_onehot_dec.sv
// 3-to-8 one-hot decoder with enable; output is all zero when en is low.
module idx_onehot_dec
    import rr_arb_pkg::*;
(
    input  logic [IDX_W_C-1:0] idx,
    input  logic               en,
    output logic [N_REQ_C-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8_dec.sv
// Round-robin arbiter for 8 requesters with registered grant index and decoded one-hot select.
// Optional hold timeout is compiled in with the RR_ARB_TIMEOUT_EN macro.
module rr_arbiter8_dec
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_REQ_C-1:0] req,
    output logic [N_REQ_C-1:0] grant,
    output logic [IDX_W_C-1:0] grant_idx,
    output logic               grant_valid,
    output logic [CNT_W-1:0]   busy_cnt
);

`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HoldLimit = CNT_W'(MAX_HOLD);

    arb_state_e         r_state, w_state_d;
    logic [IDX_W_C-1:0] r_idx, w_idx_d;
    logic [IDX_W_C-1:0] r_ptr, w_ptr_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;

    logic               w_found;
    logic [IDX_W_C-1:0] w_winner;
    logic               w_exit;

    // First requester at or after the pointer, wrapping naturally in 3 bits.
    always_comb begin
        logic [IDX_W_C-1:0] cand;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ_C; k++) begin
            cand = r_ptr + IDX_W_C'(k);
            if (!w_found && req[cand]) begin
                w_found  = 1'b1;
                w_winner = cand;
            end
        end
    end

    assign w_exit = !req[r_idx] || !en || (TimeoutEn && (r_cnt == HoldLimit));

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (en && w_found) begin
                    w_state_d = ST_GRANT;
                    w_idx_d   = w_winner;
                    w_ptr_d   = w_winner + IDX_W_C'(1);
                    w_cnt_d   = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (w_exit) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign grant_valid = (r_state == ST_GRANT);
    assign grant_idx   = r_idx;
    assign busy_cnt    = r_cnt;

    idx_onehot_dec u_dec (
        .idx    (r_idx),
        .en     (grant_valid),
        .onehot (grant)
    );

endmodule

// File: doc/rr_arbiter8_dec.md
Name: rr_arbiter8_dec

Overview:
- Round-robin arbiter that shares one 8-way selectable resource between 8 requesters.
- Picks one requester, registers its 3-bit index, and drives the one-hot select through an internal 3-to-8 decoder stage.
- Holds the grant until the requester releases it, or until an optional hold timeout expires.
- Sits in front of any 8-way select/enable fabric; upstream is 8 independent request lines.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; other values are unsupported.
- IDX_W, 3, width of the grant index. Equals log2(N_REQ).
- MAX_HOLD, 16, maximum consecutive grant cycles when the timeout feature is compiled in. Legal range 1..255.
- CNT_W, 8, width of the hold counter. Must hold MAX_HOLD.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  arbiter enable; while low no new grant is issued and any active grant is released.
- req  in  8  request lines, level-sensitive; req[i] high means requester i wants the resource.
- grant  out  8  one-hot grant, decoded from grant_idx; all zero when no grant.
- grant_idx  out  3  index of the current grantee.
- grant_valid  out  1  high while a grant is active.
- busy_cnt  out  8  cycles elapsed in the current grant, starting at 1; 0 when idle.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, grant=8'h00, grant_idx=0, grant_valid=0, busy_cnt=0, round-robin pointer ptr=0. Reset has priority over every other event, including mid-grant; the next cycle shows all-zero outputs.
- State machine, registered: IDLE and GRANT.
- IDLE -> GRANT when en=1 and req!=0.
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7, modulo 8.
  - Next cycle: grant_idx=winner, grant=1<<winner, grant_valid=1, busy_cnt=1, ptr=(winner+1) mod 8. The 3-bit wrap is natural: index 7 returns to 0.
  - Latency: request sampled in cycle n, grant visible in cycle n+1.
- IDLE stays IDLE when en=0 or req=0. Outputs stay zero and ptr is unchanged.
- GRANT -> IDLE, taking effect on the next edge, on any of:
  - req[grant_idx]=0 (release);
  - en=0;
  - with the timeout compiled in, busy_cnt==MAX_HOLD.
  - On exit: grant=0, grant_valid=0, busy_cnt=0; grant_idx keeps its last value.
- GRANT otherwise stays GRANT and busy_cnt increments, saturating at 8'hFF.
- Other requests arriving during GRANT are ignored until IDLE is reached.
- There is always exactly one IDLE cycle between consecutive grants, so the resource sees a guaranteed dead cycle.
- grant is always the decode of grant_idx gated by grant_valid. It is never multi-hot and never glitches between edges, because it is decoded from registers.
- Simultaneous release and a new request in the same cycle: release wins; the new request is arbitrated in the following IDLE cycle.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined: a grant is forcibly ended after exactly MAX_HOLD grant cycles, even if the requester still holds its request. The requester re-enters arbitration behind the others, since ptr has already advanced.
- Undefined: no timeout. A grant lasts until the request drops or en falls. busy_cnt still counts and saturates.

Decomposition:
- Package rr_arb_pkg holds:
  - localparams N_REQ_C=8 and IDX_W_C=3;
  - state encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
- One sub-module, idx_onehot_dec: combinational 3-to-8 decoder with enable (inputs idx[2:0], en; output onehot[7:0]). It is instantiated once to produce grant from grant_idx and grant_valid.
- Rotation/priority search stays in the top level.

Test Plan:
- Reset, en=1, req=8'h01 -> one cycle later grant=8'h01, grant_idx=0, grant_valid=1, busy_cnt=1. req drops -> next cycle grant=8'h00, busy_cnt=0.
- Round robin: req=8'hFF held, timeout on, MAX_HOLD=2 -> grants rotate 0,1,...,7,0. Each grant lasts 2 cycles, with 1 idle cycle between grants; grant is never multi-hot.
- Wrap and skip: ptr=6 (after granting 5), req=8'h21 -> grant_idx=0 (scan 6,7,0), then ptr=1; the next request from 5 is granted afterwards.
- Timeout macro off, req=8'h81 with req[0] high for 6 cycles -> grant=8'h01 for 6 cycles, 1 idle cycle, then grant=8'h80.
- en dropped mid-grant on requester 3 -> next cycle grant=0, grant_valid=0. While en=0 and req=8'hFF, no grant is issued.
- rst_n low during a grant with busy_cnt=5 -> next edge: all outputs 0, ptr=0. After release of reset, req=8'h0C -> grant_idx=2.
